// File: rtl/mem_pkg.sv
// Shared definitions for the IF/MEM SRAM bus arbiter: FSM state encodings,
// default bus widths and the instruction substituted when fetch loses the bus.
package mem_pkg;

  localparam int MEM_ADDR_W = 18;
  localparam int MEM_DATA_W = 16;

  localparam logic [MEM_DATA_W-1:0] NOP_INSN = 16'h0800;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_WR_SETUP = 2'd1,
    S_WR_PULSE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the pipeline-side handshake and the SRAM-side bus of mem_arbiter.
// slave: the arbiter's view. master: the pipeline plus SRAM environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_pkg::MEM_ADDR_W,
  parameter int DATA_W = mem_pkg::MEM_DATA_W
);

  logic [15:0]       if_addr;
  logic [DATA_W-1:0] if_data;
  logic [15:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_conflict;
  logic              mem_hold;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dq_o;
  logic [DATA_W-1:0] ram_dq_i;
  logic              ram_dq_oe;
  logic              ram_oe_n;
  logic              ram_we_n;
  logic              ram_ce_n;

  modport slave (
    input  if_addr, mem_addr, mem_wdata, mem_read, mem_write, ram_dq_i,
    output if_data, mem_rdata, mem_conflict, mem_hold,
           ram_addr, ram_dq_o, ram_dq_oe, ram_oe_n, ram_we_n, ram_ce_n
  );

  modport master (
    output if_addr, mem_addr, mem_wdata, mem_read, mem_write, ram_dq_i,
    input  if_data, mem_rdata, mem_conflict, mem_hold,
           ram_addr, ram_dq_o, ram_dq_oe, ram_oe_n, ram_we_n, ram_ce_n
  );

endinterface

// File: rtl/mem_wbuf.sv
// One-entry store buffer for mem_arbiter. Holds the address/data of the store
// being written to SRAM and reports whether a load address matches it, so the
// forwarding compare lives in one place.
module mem_wbuf
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [15:0]       addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [15:0]       cmp_addr,
  output logic [15:0]       wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              hit
);

  logic [15:0]       wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_valid_q, wb_valid_d;

  // Capture a new store on load; drop validity once its write pulse is done.
  always_comb begin
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = wb_valid_q;
    if (load) begin
      wb_addr_d  = addr_in;
      wb_data_d  = data_in;
      wb_valid_d = 1'b1;
    end else if (clear) begin
      wb_valid_d = 1'b0;
    end
  end

  // Buffer registers, emptied asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign hit     = wb_valid_q && (cmp_addr == wb_addr_q);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single SRAM bus between instruction fetch and the MEM stage.
// Loads take the bus in their request cycle (fetch sees NOP_INSN); stores are
// buffered and written with a setup cycle followed by a write-enable pulse.
// Optional macro MEM_ARB_WFWD_EN: loads hitting the buffered store during the
// write sequence are answered from the buffer instead of being held.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

`ifdef MEM_ARB_WFWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  arb_state_e state_q, state_d;
  logic wb_load, wb_clear, wb_hit;
  logic [15:0]         wb_addr;
  logic [MEM_DATA_W-1:0] wb_data;
  logic rd_only;

  assign rd_only = bus.mem_read && !bus.mem_write;

  mem_wbuf #(.DATA_W(MEM_DATA_W)) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .load     (wb_load),
    .clear    (wb_clear),
    .addr_in  (bus.mem_addr),
    .data_in  (bus.mem_wdata),
    .cmp_addr (bus.mem_addr),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .hit      (wb_hit)
  );

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Sequence a store through setup and pulse; accept new stores only in fetch.
  always_comb begin
    state_d  = state_q;
    wb_load  = 1'b0;
    wb_clear = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_write) begin
          wb_load = 1'b1;
          state_d = S_WR_SETUP;
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        wb_clear = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Bus muxing and handshake outputs; reset forces the SRAM safe and quiet.
  always_comb begin
    bus.ram_addr     = MEM_ADDR_W'(bus.if_addr);
    bus.ram_dq_o     = '0;
    bus.ram_dq_oe    = 1'b0;
    bus.ram_oe_n     = 1'b0;
    bus.ram_we_n     = 1'b1;
    bus.if_data      = bus.ram_dq_i;
    bus.mem_rdata    = '0;
    bus.mem_conflict = 1'b0;
    bus.mem_hold     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (rd_only) begin
          bus.ram_addr     = MEM_ADDR_W'(bus.mem_addr);
          bus.mem_rdata    = bus.ram_dq_i;
          bus.if_data      = NOP_INSN;
          bus.mem_conflict = 1'b1;
        end
      end
      S_WR_SETUP, S_WR_PULSE: begin
        bus.ram_addr     = MEM_ADDR_W'(wb_addr);
        bus.ram_dq_o     = wb_data;
        bus.ram_dq_oe    = 1'b1;
        bus.ram_oe_n     = 1'b1;
        bus.ram_we_n     = (state_q == S_WR_PULSE) ? 1'b0 : 1'b1;
        bus.if_data      = NOP_INSN;
        bus.mem_conflict = 1'b1;
        if (FWD_EN && rd_only && wb_hit) begin
          bus.mem_rdata = wb_data;
        end else if (bus.mem_read || bus.mem_write) begin
          bus.mem_hold = 1'b1;
        end
      end
      default: ;
    endcase
    if (!rst) begin
      bus.ram_we_n     = 1'b1;
      bus.ram_dq_oe    = 1'b0;
      bus.mem_conflict = 1'b0;
      bus.mem_hold     = 1'b0;
    end
  end

  assign bus.ram_ce_n = !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural SRAM model.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_mem_arbiter;

`ifdef MEM_ARB_WFWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   init_done = 1'b0;

  logic [15:0] sram [0:262143];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.ram_dq_i = sram[bus.ram_addr];

  // SRAM model: preload once, then write mid-cycle while WE# is low.
  always @(negedge clk) begin
    if (!init_done) begin
      sram[18'h00004] <= 16'h6A01;
      sram[18'h08010] <= 16'hBEEF;
      sram[18'h09000] <= 16'h5555;
      init_done <= 1'b1;
    end else if (!bus.ram_ce_n && !bus.ram_we_n && bus.ram_dq_oe) begin
      sram[bus.ram_addr] <= bus.ram_dq_o;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.if_addr = 16'h0004; bus.mem_addr = 16'h8010; bus.mem_wdata = 16'h0;
    bus.mem_read = 1'b1; bus.mem_write = 1'b0;
    #2;
    checks++; if (bus.ram_ce_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_ce_n: got %b want 1", bus.ram_ce_n); end
    checks++; if (bus.ram_we_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_we_n: got %b want 1", bus.ram_we_n); end
    checks++; if (bus.ram_dq_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_dq_oe: got %b want 0", bus.ram_dq_oe); end
    checks++; if (bus.mem_conflict !== 1'b0) begin errors++; $display("[TB] FAIL reset_conflict: got %b want 0", bus.mem_conflict); end
    checks++; if (bus.mem_hold !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold: got %b want 0", bus.mem_hold); end
    bus.mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.ram_ce_n !== 1'b0) begin errors++; $display("[TB] FAIL run_ce_n: got %b want 0", bus.ram_ce_n); end
  endtask

  task automatic test_fetch();
    bus.if_addr = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      checks++; if (bus.if_data !== 16'h6A01) begin errors++; $display("[TB] FAIL fetch_data: got %h want 6a01", bus.if_data); end
      checks++; if (bus.mem_conflict !== 1'b0) begin errors++; $display("[TB] FAIL fetch_conflict: got %b want 0", bus.mem_conflict); end
      checks++; if (bus.ram_we_n !== 1'b1) begin errors++; $display("[TB] FAIL fetch_we_n: got %b want 1", bus.ram_we_n); end
      checks++; if (bus.ram_addr !== 18'h00004) begin errors++; $display("[TB] FAIL fetch_addr: got %h want 00004", bus.ram_addr); end
    end
  endtask

  task automatic test_load();
    next_cycle();
    bus.mem_read = 1'b1; bus.mem_addr = 16'h8010;
    #1;
    checks++; if (bus.mem_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL load_rdata: got %h want beef", bus.mem_rdata); end
    checks++; if (bus.if_data !== 16'h0800) begin errors++; $display("[TB] FAIL load_if_nop: got %h want 0800", bus.if_data); end
    checks++; if (bus.mem_conflict !== 1'b1) begin errors++; $display("[TB] FAIL load_conflict: got %b want 1", bus.mem_conflict); end
    checks++; if (bus.ram_addr !== 18'h08010) begin errors++; $display("[TB] FAIL load_addr: got %h want 08010", bus.ram_addr); end
    checks++; if (bus.ram_oe_n !== 1'b0 || bus.ram_dq_oe !== 1'b0) begin errors++; $display("[TB] FAIL load_oe: got oe_n=%b dq_oe=%b want 0/0", bus.ram_oe_n, bus.ram_dq_oe); end
    bus.mem_read = 1'b0;
    #1;
    checks++; if (bus.mem_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL idle_rdata: got %h want 0000", bus.mem_rdata); end
  endtask

  task automatic test_store();
    next_cycle();
    bus.mem_write = 1'b1; bus.mem_addr = 16'h8020; bus.mem_wdata = 16'h1234;
    #1;
    checks++; if (bus.if_data !== 16'h6A01 || bus.mem_conflict !== 1'b0) begin errors++; $display("[TB] FAIL store_req_fetch: got %h/%b want 6a01/0", bus.if_data, bus.mem_conflict); end
    next_cycle();
    bus.mem_write = 1'b0;
    #1;
    checks++; if (bus.ram_dq_oe !== 1'b1 || bus.ram_we_n !== 1'b1 || bus.ram_oe_n !== 1'b1) begin errors++; $display("[TB] FAIL setup_ctrl: got dq_oe=%b we_n=%b oe_n=%b want 1/1/1", bus.ram_dq_oe, bus.ram_we_n, bus.ram_oe_n); end
    checks++; if (bus.mem_conflict !== 1'b1 || bus.if_data !== 16'h0800) begin errors++; $display("[TB] FAIL setup_conflict: got %b/%h want 1/0800", bus.mem_conflict, bus.if_data); end
    checks++; if (bus.ram_addr !== 18'h08020 || bus.ram_dq_o !== 16'h1234) begin errors++; $display("[TB] FAIL setup_bus: got %h/%h want 08020/1234", bus.ram_addr, bus.ram_dq_o); end
    next_cycle(); #1;
    checks++; if (bus.ram_we_n !== 1'b0 || bus.ram_dq_oe !== 1'b1) begin errors++; $display("[TB] FAIL pulse_ctrl: got we_n=%b dq_oe=%b want 0/1", bus.ram_we_n, bus.ram_dq_oe); end
    next_cycle(); #1;
    checks++; if (bus.ram_we_n !== 1'b1 || bus.mem_conflict !== 1'b0 || bus.if_data !== 16'h6A01) begin errors++; $display("[TB] FAIL store_resume: got we_n=%b conf=%b if=%h want 1/0/6a01", bus.ram_we_n, bus.mem_conflict, bus.if_data); end
    bus.mem_read = 1'b1; bus.mem_addr = 16'h8020;
    #1;
    checks++; if (bus.mem_rdata !== 16'h1234) begin errors++; $display("[TB] FAIL store_readback: got %h want 1234", bus.mem_rdata); end
    bus.mem_read = 1'b0;
  endtask

  task automatic test_store_then_load();
    next_cycle();
    bus.mem_write = 1'b1; bus.mem_addr = 16'h8040; bus.mem_wdata = 16'h7777;
    next_cycle();
    bus.mem_write = 1'b0; bus.mem_read = 1'b1; bus.mem_addr = 16'h9000;
    #1;
    checks++; if (bus.mem_hold !== 1'b1 || bus.mem_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL stld_hold1: got %b/%h want 1/0000", bus.mem_hold, bus.mem_rdata); end
    next_cycle(); #1;
    checks++; if (bus.mem_hold !== 1'b1) begin errors++; $display("[TB] FAIL stld_hold2: got %b want 1", bus.mem_hold); end
    next_cycle(); #1;
    checks++; if (bus.mem_hold !== 1'b0 || bus.mem_conflict !== 1'b1 || bus.mem_rdata !== 16'h5555) begin errors++; $display("[TB] FAIL stld_served: got hold=%b conf=%b rd=%h want 0/1/5555", bus.mem_hold, bus.mem_conflict, bus.mem_rdata); end
    bus.mem_read = 1'b0;
    checks++; if (sram[18'h09000] !== 16'h5555 || sram[18'h08040] !== 16'h7777) begin errors++; $display("[TB] FAIL stld_sram: got %h/%h want 5555/7777", sram[18'h09000], sram[18'h08040]); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    bus.mem_write = 1'b1; bus.mem_addr = 16'h8050; bus.mem_wdata = 16'h1111;
    next_cycle();
    bus.mem_addr = 16'h8060; bus.mem_wdata = 16'h2222;
    #1;
    checks++; if (bus.mem_hold !== 1'b1) begin errors++; $display("[TB] FAIL b2b_hold1: got %b want 1", bus.mem_hold); end
    next_cycle(); #1;
    checks++; if (bus.mem_hold !== 1'b1) begin errors++; $display("[TB] FAIL b2b_hold2: got %b want 1", bus.mem_hold); end
    next_cycle(); #1;
    checks++; if (bus.mem_hold !== 1'b0 || bus.mem_conflict !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept: got hold=%b conf=%b want 0/0", bus.mem_hold, bus.mem_conflict); end
    next_cycle();
    bus.mem_write = 1'b0;
    #1;
    checks++; if (bus.ram_addr !== 18'h08060 || bus.ram_dq_o !== 16'h2222) begin errors++; $display("[TB] FAIL b2b_bus: got %h/%h want 08060/2222", bus.ram_addr, bus.ram_dq_o); end
    repeat (2) next_cycle();
    checks++; if (sram[18'h08050] !== 16'h1111 || sram[18'h08060] !== 16'h2222) begin errors++; $display("[TB] FAIL b2b_sram: got %h/%h want 1111/2222", sram[18'h08050], sram[18'h08060]); end
  endtask

  task automatic test_forward();
    logic [15:0] exp_rd;
    logic        exp_hold;
    exp_rd   = FWD ? 16'hA5A5 : 16'h0000;
    exp_hold = FWD ? 1'b0 : 1'b1;
    next_cycle();
    bus.mem_write = 1'b1; bus.mem_addr = 16'h8030; bus.mem_wdata = 16'hA5A5;
    next_cycle();
    bus.mem_write = 1'b0; bus.mem_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.mem_hold !== exp_hold || bus.mem_rdata !== exp_rd) begin errors++; $display("[TB] FAIL fwd_wr%0d: got hold=%b rd=%h want %b/%h", i, bus.mem_hold, bus.mem_rdata, exp_hold, exp_rd); end
      checks++; if (bus.ram_addr !== 18'h08030 || bus.ram_dq_oe !== 1'b1) begin errors++; $display("[TB] FAIL fwd_bus%0d: got %h/%b want 08030/1", i, bus.ram_addr, bus.ram_dq_oe); end
      next_cycle();
    end
    #1;
    checks++; if (bus.mem_hold !== 1'b0 || bus.mem_rdata !== 16'hA5A5) begin errors++; $display("[TB] FAIL fwd_after: got hold=%b rd=%h want 0/a5a5", bus.mem_hold, bus.mem_rdata); end
    bus.mem_read = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    next_cycle();
    bus.mem_write = 1'b1; bus.mem_addr = 16'h8070; bus.mem_wdata = 16'h3333;
    next_cycle();
    bus.mem_write = 1'b0;
    next_cycle();
    bus.mem_read = 1'b1;
    #1;
    checks++; if (bus.ram_we_n !== 1'b0 || bus.mem_hold !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_pulse: got we_n=%b hold=%b want 0/1", bus.ram_we_n, bus.mem_hold); end
    rst = 1'b0;
    #1;
    checks++; if (bus.ram_we_n !== 1'b1 || bus.ram_dq_oe !== 1'b0) begin errors++; $display("[TB] FAIL async_rst: got we_n=%b dq_oe=%b want 1/0", bus.ram_we_n, bus.ram_dq_oe); end
    checks++; if (bus.mem_hold !== 1'b0 || bus.mem_conflict !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_hs: got hold=%b conf=%b want 0/0", bus.mem_hold, bus.mem_conflict); end
    bus.mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    next_cycle(); #1;
    checks++; if (bus.mem_hold !== 1'b0 || bus.mem_conflict !== 1'b0 || bus.if_data !== 16'h6A01 || bus.ram_dq_oe !== 1'b0) begin errors++; $display("[TB] FAIL post_rst: got hold=%b conf=%b if=%h dq_oe=%b want 0/0/6a01/0", bus.mem_hold, bus.mem_conflict, bus.if_data, bus.ram_dq_oe); end
    bus.mem_write = 1'b1; bus.mem_addr = 16'h8080; bus.mem_wdata = 16'h4444;
    next_cycle();
    bus.mem_write = 1'b0;
    #1;
    checks++; if (bus.ram_addr !== 18'h08080 || bus.ram_we_n !== 1'b1 || bus.ram_dq_oe !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_setup: got %h we_n=%b dq_oe=%b want 08080/1/1", bus.ram_addr, bus.ram_we_n, bus.ram_dq_oe); end
    repeat (2) next_cycle();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_store_then_load();
    test_back_to_back();
    test_forward();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
